// File: rtl/led_s2p_rx.sv
// Serial-to-parallel receiver for the LED shift-chain link, oversampled on clk.
// Define LED_S2P_SYNC_EN to put a two-flop synchronizer on the four serial pins.
module led_s2p_rx #(
  parameter int DATA_BITS = 16,
  parameter bit DIR       = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sclk,
  input  logic                 sclrn,
  input  logic                 sin,
  input  logic                 en,
  output logic [DATA_BITS-1:0] pdata,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy,
  output logic [7:0]           frame_cnt
);
  localparam int CW = $clog2(DATA_BITS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_BITS);
  localparam logic [CW-1:0] CNT_OVER = CW'(DATA_BITS + 1);

  // Pin order: {sclk, sclrn, sin, en}; all take the same path so sin stays aligned with sclk.
  logic [3:0] pins_s;

`ifdef LED_S2P_SYNC_EN
  logic [3:0] sync1_q, sync2_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {sclk, sclrn, sin, en};
      sync2_q <= sync1_q;
    end
  end
  assign pins_s = sync2_q;
`else
  assign pins_s = {sclk, sclrn, sin, en};
`endif

  logic sclk_s, sclrn_s, sin_s, en_s;
  assign {sclk_s, sclrn_s, sin_s, en_s} = pins_s;

  logic                 sclk_d_q, en_d_q;
  logic [DATA_BITS-1:0] sr_q, sr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] pdata_q, pdata_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic                 busy_q;
  logic [7:0]           fcnt_q, fcnt_d;

  logic          sclk_rise, en_rise;
  logic [CW-1:0] cnt_base;

  assign sclk_rise = sclk_s & ~sclk_d_q;
  assign en_rise   = en_s & ~en_d_q;
  // A coincident latch restarts the count, so the shift in the same cycle counts as bit 1.
  assign cnt_base  = en_rise ? '0 : cnt_q;

  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    pdata_d = pdata_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    fcnt_d  = fcnt_q;
    if (!sclrn_s) begin
      sr_d  = '0;
      cnt_d = '0;
    end else begin
      if (en_rise) begin
        if (cnt_q == CNT_FULL) begin
          pdata_d = sr_q;
          valid_d = 1'b1;
          fcnt_d  = fcnt_q + 8'd1;
        end else begin
          err_d = 1'b1;
        end
        cnt_d = '0;
      end
      if (sclk_rise) begin
        if (DIR == 1'b0) sr_d = {sr_q[DATA_BITS-2:0], sin_s};
        else             sr_d = {sin_s, sr_q[DATA_BITS-1:1]};
        cnt_d = (cnt_base == CNT_OVER) ? cnt_base : cnt_base + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_d_q <= 1'b0;
      en_d_q   <= 1'b0;
      sr_q     <= '0;
      cnt_q    <= '0;
      pdata_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      sclk_d_q <= sclk_s;
      en_d_q   <= en_s;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      pdata_q  <= pdata_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      busy_q   <= (cnt_d != '0);
      fcnt_q   <= fcnt_d;
    end
  end

  assign pdata     = pdata_q;
  assign valid     = valid_q;
  assign frame_err = err_q;
  assign busy      = busy_q;
  assign frame_cnt = fcnt_q;
endmodule

// File: tb/tb_led_s2p_rx.sv
// Directed bench for led_s2p_rx: left- and right-shift instances share one serial stream.
module tb_led_s2p_rx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sclk = 1'b0, sclrn = 1'b1, sin = 1'b0, en = 1'b0;

  logic [15:0] pdata0, pdata1;
  logic        valid0, valid1, ferr0, ferr1, busy0, busy1;
  logic [7:0]  fcnt0, fcnt1;

  int checks = 0;
  int errors = 0;
  int nv0 = 0, ne0 = 0, nv1 = 0, ne1 = 0, longp = 0, both = 0;
  logic pv0 = 1'b0, pe0 = 1'b0;

  always #5 clk = ~clk;

  led_s2p_rx #(.DATA_BITS(16), .DIR(1'b0)) dut0 (
    .clk(clk), .rst(rst), .sclk(sclk), .sclrn(sclrn), .sin(sin), .en(en),
    .pdata(pdata0), .valid(valid0), .frame_err(ferr0), .busy(busy0), .frame_cnt(fcnt0));

  led_s2p_rx #(.DATA_BITS(16), .DIR(1'b1)) dut1 (
    .clk(clk), .rst(rst), .sclk(sclk), .sclrn(sclrn), .sin(sin), .en(en),
    .pdata(pdata1), .valid(valid1), .frame_err(ferr1), .busy(busy1), .frame_cnt(fcnt1));

  // Pulse bookkeeping, sampled mid-cycle.
  always @(negedge clk) begin
    if (valid0) nv0++;
    if (ferr0)  ne0++;
    if (valid1) nv1++;
    if (ferr1)  ne1++;
    if ((valid0 && pv0) || (ferr0 && pe0)) longp++;
    if ((valid0 && ferr0) || (valid1 && ferr1)) both++;
    pv0 = valid0;
    pe0 = ferr0;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] w, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      sin = w[i]; sclk = 1'b0; cyc(3);
      sclk = 1'b1; cyc(3);
      sclk = 1'b0;
    end
    sin = 1'b0;
    cyc(5);
  endtask

  task automatic latch();
    en = 1'b1; cyc(3);
    en = 1'b0; cyc(5);
  endtask

  task automatic clear_pulse();
    sclrn = 1'b0; cyc(3);
    sclrn = 1'b1; cyc(5);
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc(3);
    rst = 1'b0; cyc(1);
    checks++; if (pdata0 !== 16'h0) begin errors++; $display("FAIL reset_pdata got %h exp 0000", pdata0); end
    checks++; if ({valid0, ferr0, busy0} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {valid0, ferr0, busy0}); end
    checks++; if (fcnt0 !== 8'd0) begin errors++; $display("FAIL reset_fcnt got %0d exp 0", fcnt0); end
  endtask

  task automatic test_dir0();
    int v = nv0, e = ne0;
    clear_pulse();
    send_bits(32'hA5C3, 16);
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL dir0_busy_full got %b exp 1", busy0); end
    checks++; if (dut0.cnt_q !== 5'd16) begin errors++; $display("FAIL dir0_cnt_full got %0d exp 16", dut0.cnt_q); end
    latch();
    checks++; if (pdata0 !== 16'hA5C3) begin errors++; $display("FAIL dir0_pdata got %h exp a5c3", pdata0); end
    checks++; if (nv0 - v !== 1 || ne0 - e !== 0) begin errors++; $display("FAIL dir0_pulses got v%0d e%0d exp v1 e0", nv0 - v, ne0 - e); end
    checks++; if (fcnt0 !== 8'd1) begin errors++; $display("FAIL dir0_fcnt got %0d exp 1", fcnt0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL dir0_busy_after got %b exp 0", busy0); end
  endtask

  task automatic test_dir1();
    int v = nv1;
    send_bits(32'hA5C3, 16);
    latch();
    checks++; if (pdata1 !== 16'hC3A5) begin errors++; $display("FAIL dir1_pdata got %h exp c3a5", pdata1); end
    checks++; if (nv1 - v !== 1) begin errors++; $display("FAIL dir1_valid got %0d exp 1", nv1 - v); end
    checks++; if (fcnt1 !== 8'd2) begin errors++; $display("FAIL dir1_fcnt got %0d exp 2", fcnt1); end
  endtask

  task automatic test_short();
    int v = nv0, e = ne0;
    send_bits(32'h7FFF, 15);
    latch();
    checks++; if (ne0 - e !== 1 || nv0 - v !== 0) begin errors++; $display("FAIL short_pulses got v%0d e%0d exp v0 e1", nv0 - v, ne0 - e); end
    checks++; if (pdata0 !== 16'hA5C3) begin errors++; $display("FAIL short_pdata got %h exp a5c3", pdata0); end
    checks++; if (dut0.cnt_q !== 5'd0 || busy0 !== 1'b0) begin errors++; $display("FAIL short_cnt got %0d/%b exp 0/0", dut0.cnt_q, busy0); end
  endtask

  task automatic test_over();
    int v = nv0, e = ne0;
    send_bits(32'h3FFFF, 18);
    checks++; if (dut0.cnt_q !== 5'd17) begin errors++; $display("FAIL over_cnt got %0d exp 17", dut0.cnt_q); end
    latch();
    checks++; if (ne0 - e !== 1 || nv0 - v !== 0) begin errors++; $display("FAIL over_pulses got v%0d e%0d exp v0 e1", nv0 - v, ne0 - e); end
    checks++; if (pdata0 !== 16'hA5C3) begin errors++; $display("FAIL over_pdata got %h exp a5c3", pdata0); end
  endtask

  task automatic test_sclrn();
    int v = nv0, e = ne0;
    send_bits(32'hFF, 8);
    clear_pulse();
    checks++; if (dut0.cnt_q !== 5'd0 || busy0 !== 1'b0) begin errors++; $display("FAIL sclrn_cnt got %0d/%b exp 0/0", dut0.cnt_q, busy0); end
    send_bits(32'h1234, 16);
    latch();
    checks++; if (pdata0 !== 16'h1234) begin errors++; $display("FAIL sclrn_pdata got %h exp 1234", pdata0); end
    checks++; if (ne0 - e !== 0 || nv0 - v !== 1) begin errors++; $display("FAIL sclrn_pulses got v%0d e%0d exp v1 e0", nv0 - v, ne0 - e); end
  endtask

  task automatic test_back_to_back();
    int v = nv0, e = ne0;
    send_bits(32'h5A5A, 16);
    sin = 1'b1; sclk = 1'b0; cyc(3);
    sclk = 1'b1; en = 1'b1; cyc(3);
    sclk = 1'b0; en = 1'b0; cyc(5);
    checks++; if (pdata0 !== 16'h5A5A) begin errors++; $display("FAIL b2b_pdata got %h exp 5a5a", pdata0); end
    checks++; if (nv0 - v !== 1 || ne0 - e !== 0) begin errors++; $display("FAIL b2b_pulses got v%0d e%0d exp v1 e0", nv0 - v, ne0 - e); end
    checks++; if (busy0 !== 1'b1 || dut0.cnt_q !== 5'd1) begin errors++; $display("FAIL b2b_cnt got %0d/%b exp 1/1", dut0.cnt_q, busy0); end
    checks++; if (fcnt0 !== 8'd4) begin errors++; $display("FAIL b2b_fcnt got %0d exp 4", fcnt0); end
    clear_pulse();
  endtask

  task automatic test_reset_wrap();
    int v, e;
    send_bits(32'h2AA, 10);
    e = ne0;
    rst = 1'b1; cyc(2);
    rst = 1'b0; cyc(1);
    checks++; if (pdata0 !== 16'h0 || fcnt0 !== 8'd0) begin errors++; $display("FAIL mid_rst_data got %h/%0d exp 0000/0", pdata0, fcnt0); end
    checks++; if ({valid0, ferr0, busy0} !== 3'b000 || dut0.cnt_q !== 5'd0) begin errors++; $display("FAIL mid_rst_flags got %b cnt %0d exp 000 cnt 0", {valid0, ferr0, busy0}, dut0.cnt_q); end
    cyc(5);
    checks++; if (ne0 - e !== 0) begin errors++; $display("FAIL mid_rst_err got %0d exp 0", ne0 - e); end
    v = nv0; e = ne0;
    for (int i = 0; i < 256; i++) begin
      send_bits(32'h1000 + i, 16);
      latch();
    end
    checks++; if (fcnt0 !== 8'd0) begin errors++; $display("FAIL wrap_fcnt got %0d exp 0", fcnt0); end
    checks++; if (nv0 - v !== 256 || ne0 - e !== 0) begin errors++; $display("FAIL wrap_pulses got v%0d e%0d exp v256 e0", nv0 - v, ne0 - e); end
    checks++; if (pdata0 !== 16'h10FF) begin errors++; $display("FAIL wrap_pdata got %h exp 10ff", pdata0); end
  endtask

  task automatic test_pulse_shape();
    checks++; if (longp !== 0) begin errors++; $display("FAIL pulse_width got %0d long pulses exp 0", longp); end
    checks++; if (both !== 0) begin errors++; $display("FAIL pulse_overlap got %0d exp 0", both); end
  endtask

  initial begin
    test_reset();
    test_dir0();
    test_dir1();
    test_short();
    test_over();
    test_sclrn();
    test_back_to_back();
    test_reset_wrap();
    test_pulse_shape();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
